// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states, the IF-stage NOP,
// and the legal wait-state range that sizes the wait counter.
package mem_arb_pkg;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DATA  = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam int          WAIT_STATES_MIN = 0;
    localparam int          WAIT_STATES_MAX = 3;
    localparam int          WCNT_W          = $clog2(WAIT_STATES_MAX + 1);

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: one cycle per increment, synchronous clear has priority,
// holds at all-ones; no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one memory port between IF fetch and MEM load/store, data first; each access is
// 1+WAIT_STATES cycles and the pipeline is held through stall_if / stall_mem.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_valid,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [WCNT_W-1:0] WS_LAST = WCNT_W'(WAIT_STATES);

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              data_req, last, ld_only;
    logic              fetch_done, data_done, ld_done;
    logic [ADDR_W-1:0] addr_c;
    logic              rd_c, wr_c;

    assign data_req = d_rd | d_wr;
    assign ld_only  = d_rd & ~d_wr;
    assign last     = (wcnt == WS_LAST);
    assign ld_done  = data_done & ld_only;

    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        addr_c     = if_addr;
        rd_c       = 1'b0;
        wr_c       = 1'b0;
        fetch_done = 1'b0;
        data_done  = 1'b0;
        case (state)
            S_FETCH: begin
                // A fetch already under way (wcnt>0) is never pre-empted.
                if (data_req && (wcnt == '0)) begin
                    addr_c = d_addr;
                    rd_c   = ld_only;
                    if (last) begin
                        wr_c      = d_wr;
                        data_done = 1'b1;
                    end else begin
                        state_nxt = S_DATA;
                        wcnt_nxt  = wcnt + WCNT_W'(1);
                    end
                end else begin
                    addr_c = if_addr;
                    rd_c   = if_req;
                    if (!if_req) begin
                        wcnt_nxt = '0;
                    end else if (last) begin
                        fetch_done = 1'b1;
                        wcnt_nxt   = '0;
                    end else begin
                        wcnt_nxt = wcnt + WCNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                addr_c = d_addr;
                rd_c   = ld_only;
                // A request withdrawn mid-access is dropped rather than left hanging.
                if (!data_req) begin
                    state_nxt = S_FETCH;
                    wcnt_nxt  = '0;
                end else if (last) begin
                    wr_c      = d_wr;
                    data_done = 1'b1;
                    state_nxt = S_FETCH;
                    wcnt_nxt  = '0;
                end else begin
                    wcnt_nxt = wcnt + WCNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_FETCH;
                wcnt_nxt  = '0;
            end
        endcase
    end

    // Outputs are gated while reset is low so an interrupted store never reaches memory.
    always_comb begin
        mem_addr     = addr_c;
        mem_rd       = rd_c;
        mem_wr       = wr_c;
        mem_wdata    = d_wdata;
        if_valid     = fetch_done;
        if_data      = mem_rdata;
        d_done       = data_done;
        d_rdata      = ld_done ? mem_rdata : rdata_q;
        stall_mem    = data_req & ~data_done;
        stall_if     = if_req & ~fetch_done;
        conflict_cnt = cnt_q;
        if (!rst) begin
            mem_addr     = '0;
            mem_rd       = 1'b0;
            mem_wr       = 1'b0;
            mem_wdata    = '0;
            if_valid     = 1'b0;
            if_data      = '0;
            d_done       = 1'b0;
            d_rdata      = '0;
            stall_mem    = 1'b0;
            stall_if     = 1'b0;
            conflict_cnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_FETCH;
            wcnt    <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (ld_done) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_conflict_cnt (
        .clk (clk),
        .clr (~rst),
        .inc (stall_if),
        .q   (cnt_q)
    );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Four arbiters (WAIT_STATES 0..3, 2-bit counters) each on its own behavioural memory;
// directed stimulus queues expectations, a negedge monitor pops and compares them.
module tb_unified_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NI = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req       [NI];
    logic [AW-1:0] if_addr      [NI];
    logic [DW-1:0] if_data      [NI];
    logic          if_valid     [NI];
    logic          d_rd         [NI];
    logic          d_wr         [NI];
    logic [AW-1:0] d_addr       [NI];
    logic [DW-1:0] d_wdata      [NI];
    logic [DW-1:0] d_rdata      [NI];
    logic          d_done       [NI];
    logic          stall_if     [NI];
    logic          stall_mem    [NI];
    logic [AW-1:0] mem_addr     [NI];
    logic          mem_rd       [NI];
    logic          mem_wr       [NI];
    logic [DW-1:0] mem_wdata    [NI];
    logic [DW-1:0] mem_rdata    [NI];
    logic [CW-1:0] conflict_cnt [NI];

    function automatic logic [31:0] init_val(int a);
        if (a == 5) return 32'hDEAD_BEEF;
        return 32'h0A00_0000 + 32'(a);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [DW-1:0] mem [64];

        initial begin
            for (int i = 0; i < 64; i++) mem[i] = init_val(i);
            forever begin
                @(posedge clk);
                if (mem_wr[g]) mem[mem_addr[g]] <= mem_wdata[g];
            end
        end

        assign mem_rdata[g] = mem[mem_addr[g]];

        unified_mem_arbiter #(
            .ADDR_W      (AW),
            .DATA_W      (DW),
            .WAIT_STATES (g),
            .CNT_W       (CW)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .if_req       (if_req[g]),
            .if_addr      (if_addr[g]),
            .if_data      (if_data[g]),
            .if_valid     (if_valid[g]),
            .d_rd         (d_rd[g]),
            .d_wr         (d_wr[g]),
            .d_addr       (d_addr[g]),
            .d_wdata      (d_wdata[g]),
            .d_rdata      (d_rdata[g]),
            .d_done       (d_done[g]),
            .stall_if     (stall_if[g]),
            .stall_mem    (stall_mem[g]),
            .mem_addr     (mem_addr[g]),
            .mem_rd       (mem_rd[g]),
            .mem_wr       (mem_wr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_rdata    (mem_rdata[g]),
            .conflict_cnt (conflict_cnt[g])
        );
    end

    typedef struct {
        int          g;
        logic [31:0] val;
    } dexp_t;

    typedef struct {
        int         g;
        string      name;
        logic [7:0] val;
    } cexp_t;

    dexp_t fq[$];
    dexp_t dq[$];
    cexp_t cq[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    // {mem_rd, stall_if, stall_mem, mem_wr, if_valid, d_done, conflict_cnt[1:0]}
    function automatic logic [7:0] ctl_of(int g);
        return {mem_rd[g], stall_if[g], stall_mem[g], mem_wr[g],
                if_valid[g], d_done[g], conflict_cnt[g]};
    endfunction

    always @(negedge clk) begin : mon
        dexp_t      e;
        cexp_t      c;
        logic [7:0] a;
        for (int g = 0; g < NI; g++) begin
            if (if_valid[g]) begin
                n_cmp++;
                if (fq.size() != 0 && fq[0].g == g) begin
                    e = fq.pop_front();
                    if (if_data[g] !== e.val) begin
                        n_fail++;
                        $display("FAIL fetch_data[%0d]: got %h want %h", g, if_data[g], e.val);
                    end
                end else begin
                    n_fail++;
                    $display("FAIL fetch_unexpected[%0d]: if_valid with data %h, none expected", g, if_data[g]);
                end
            end
            if (d_done[g]) begin
                n_cmp++;
                if (dq.size() != 0 && dq[0].g == g) begin
                    e = dq.pop_front();
                    if (d_rdata[g] !== e.val) begin
                        n_fail++;
                        $display("FAIL data_rdata[%0d]: got %h want %h", g, d_rdata[g], e.val);
                    end
                end else begin
                    n_fail++;
                    $display("FAIL data_unexpected[%0d]: d_done with rdata %h, none expected", g, d_rdata[g]);
                end
            end
        end
        if (cq.size() != 0) begin
            c = cq.pop_front();
            a = ctl_of(c.g);
            n_cmp++;
            if (a !== c.val) begin
                n_fail++;
                $display("FAIL %s[%0d]: rd/sif/smem/wr/ifv/done/cnt got %b want %b", c.name, c.g, a, c.val);
            end
        end
    end

    task automatic set_if(int g, logic r, logic [AW-1:0] a);
        if_req[g]  = r;
        if_addr[g] = a;
    endtask

    task automatic set_d(int g, logic rd, logic wr, logic [AW-1:0] a, logic [DW-1:0] wd);
        d_rd[g]    = rd;
        d_wr[g]    = wr;
        d_addr[g]  = a;
        d_wdata[g] = wd;
    endtask

    task automatic step(int g, string name, logic [7:0] val);
        cq.push_back('{g, name, val});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        for (int g = 0; g < NI; g++) begin
            set_if(g, 1'b0, 6'd0);
            set_d(g, 1'b0, 1'b0, 6'd0, 32'd0);
        end
        @(posedge clk);
        #1;

        // Requests during reset must not reach any output.
        set_if(0, 1'b1, 6'd1);
        set_d(0, 1'b1, 1'b1, 6'd2, 32'hFFFF_FFFF);
        step(0, "reset_forced", 8'b0000_0000);
        step(0, "reset_forced", 8'b0000_0000);
        rst = 1'b1;
        set_d(0, 1'b0, 1'b0, 6'd0, 32'd0);

        // WAIT_STATES=0: fetch stream
        for (int k = 0; k < 4; k++) begin
            set_if(0, 1'b1, 6'(k));
            fq.push_back('{0, init_val(k)});
            step(0, "ws0_fetch", 8'b1000_1000);
        end

        // WAIT_STATES=0: single load costs one fetch bubble
        set_if(0, 1'b1, 6'd4);
        set_d(0, 1'b1, 1'b0, 6'd5, 32'd0);
        dq.push_back('{0, 32'hDEAD_BEEF});
        step(0, "ws0_load", 8'b1100_0100);
        set_d(0, 1'b0, 1'b0, 6'd0, 32'd0);
        fq.push_back('{0, init_val(4)});
        step(0, "ws0_fetch_after_load", 8'b1000_1001);

        // rd and wr together behave as a store; d_rdata holds the last load
        set_d(0, 1'b1, 1'b1, 6'd20, 32'hCAFE_F00D);
        dq.push_back('{0, 32'hDEAD_BEEF});
        step(0, "ws0_rdwr_store", 8'b0101_0101);
        set_d(0, 1'b0, 1'b0, 6'd0, 32'd0);
        set_if(0, 1'b1, 6'd20);
        fq.push_back('{0, 32'hCAFE_F00D});
        step(0, "ws0_fetch_stored", 8'b1000_1010);

        // Back-to-back loads drive the 2-bit counter into saturation
        for (int j = 0; j < 5; j++) begin
            set_d(0, 1'b1, 1'b0, 6'(10 + j), 32'd0);
            dq.push_back('{0, init_val(10 + j)});
            step(0, "ws0_sat_load", {6'b110001, (j == 0) ? 2'd2 : 2'd3});
        end
        set_d(0, 1'b0, 1'b0, 6'd0, 32'd0);
        set_if(0, 1'b1, 6'd21);
        fq.push_back('{0, init_val(21)});
        step(0, "ws0_sat_hold", 8'b1000_1011);
        set_if(0, 1'b0, 6'd0);
        step(0, "ws0_idle", 8'b0000_0011);

        // WAIT_STATES=1: load arrives during a fetch
        set_if(1, 1'b1, 6'd8);
        step(1, "ws1_fetch_c0", 8'b1100_0000);
        set_d(1, 1'b1, 1'b0, 6'd9, 32'd0);
        fq.push_back('{1, init_val(8)});
        step(1, "ws1_fetch_done", 8'b1010_1001);
        set_if(1, 1'b1, 6'd9);
        step(1, "ws1_load_c0", 8'b1110_0001);
        dq.push_back('{1, init_val(9)});
        step(1, "ws1_load_done", 8'b1100_0110);
        set_d(1, 1'b0, 1'b0, 6'd0, 32'd0);
        step(1, "ws1_fetch2_c0", 8'b1100_0011);
        fq.push_back('{1, init_val(9)});
        step(1, "ws1_fetch2_done", 8'b1000_1011);
        set_if(1, 1'b0, 6'd0);

        // WAIT_STATES=2: store, then fetch the stored word back
        set_if(2, 1'b1, 6'd7);
        set_d(2, 1'b0, 1'b1, 6'd3, 32'h1234_5678);
        step(2, "ws2_store_c0", 8'b0110_0000);
        step(2, "ws2_store_c1", 8'b0110_0001);
        dq.push_back('{2, 32'd0});
        step(2, "ws2_store_c2", 8'b0101_0110);
        set_d(2, 1'b0, 1'b0, 6'd0, 32'd0);
        set_if(2, 1'b1, 6'd3);
        step(2, "ws2_fetch_c0", 8'b1100_0011);
        step(2, "ws2_fetch_c1", 8'b1100_0011);
        fq.push_back('{2, 32'h1234_5678});
        step(2, "ws2_fetch_c2", 8'b1000_1011);
        set_if(2, 1'b0, 6'd0);

        // WAIT_STATES=3: reset in the second cycle of a store
        set_d(3, 1'b0, 1'b1, 6'd12, 32'hBAD0_BAD0);
        step(3, "ws3_store_c0", 8'b0010_0000);
        rst = 1'b0;
        step(3, "ws3_reset_c1", 8'b0000_0000);
        step(3, "ws3_reset_c2", 8'b0000_0000);
        rst = 1'b1;
        set_d(3, 1'b0, 1'b0, 6'd0, 32'd0);
        step(3, "ws3_after_reset", 8'b0000_0000);
        set_if(3, 1'b1, 6'd12);
        step(3, "ws3_fetch_c0", 8'b1100_0000);
        step(3, "ws3_fetch_c1", 8'b1100_0001);
        step(3, "ws3_fetch_c2", 8'b1100_0010);
        fq.push_back('{3, init_val(12)});
        step(3, "ws3_fetch_c3", 8'b1000_1011);
        set_if(3, 1'b0, 6'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        while (fq.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL fetch_missing[%0d]: no if_valid, want data %h", fq[0].g, fq[0].val);
            void'(fq.pop_front());
        end
        while (dq.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL data_missing[%0d]: no d_done, want rdata %h", dq[0].g, dq[0].val);
            void'(dq.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbiter and sequencer for the single-ported unified instruction/data memory of the 5-stage RISC-V pipeline. It shares the one memory port between the IF-stage fetch and MEM-stage loads/stores, and gives data accesses priority. It drives the stall signals that hold the PC/IF_ID registers and the EX_MEM/MEM_WB registers, supports a configurable number of memory wait states, and keeps a saturating count of fetch cycles lost to conflicts.

## Interface
Parameters:
- ADDR_W, 6, word-address width (memory word index)
- DATA_W, 32, data width
- WAIT_STATES, 0, extra cycles per memory access (legal 0..3); each access takes 1+WAIT_STATES cycles
- CNT_W, 16, width of conflict counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- if_req  in  1  fetch request from IF stage
- if_addr  in  ADDR_W  fetch word address (pc[7:2])
- if_data  out  DATA_W  fetched instruction, valid when if_valid=1
- if_valid  out  1  fetch completes this cycle
- d_rd  in  1  MEM-stage load request
- d_wr  in  1  MEM-stage store request
- d_addr  in  ADDR_W  data word address (alu_out[7:2])
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_done  out  1  data access completes this cycle
- stall_if  out  1  hold PC and IF_ID, inject bubble into IF_ID
- stall_mem  out  1  hold EX_MEM and MEM_WB, and everything upstream
- mem_addr  out  ADDR_W  memory address
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (combinational read)
- conflict_cnt  out  CNT_W  saturating count of lost fetch cycles

## Operation
- FSM states: S_FETCH (port owned by fetch, or idle), S_DATA (data access in progress). A wait counter wcnt runs from 0 to WAIT_STATES.
- S_FETCH with d_rd|d_wr=1 and no fetch in progress (wcnt=0): data wins. The same cycle drives the data address, and the state goes to S_DATA unless the access completes in this cycle.
- S_FETCH with no data request: mem_addr=if_addr, mem_rd=if_req. The fetch completes when wcnt=WAIT_STATES, giving if_valid=1 and if_data=mem_rdata.
- Fetch is non-preemptive. A data request that arrives while a fetch has wcnt>0 waits until that fetch completes, with stall_mem=1. The data access starts on the next cycle.
- S_DATA: mem_addr=d_addr, mem_rd=d_rd. mem_wr=d_wr is asserted only in the completing cycle (wcnt=WAIT_STATES). On completion: d_done=1, back to S_FETCH, wcnt=0.
- d_rd and d_wr both high: treated as a store. mem_rd=0 and d_rdata holds its value.
- d_rd, d_wr, d_addr and d_wdata must be held stable until d_done. The pipeline guarantees this through stall_mem.
- stall_mem = (d_rd|d_wr) & ~d_done.
- stall_if = if_req & ~if_valid. When stall_if=1, the IF_ID input becomes a NOP bubble (the bubble mux lives outside this block).
- d_rdata: combinational mem_rdata in the completing load cycle. Otherwise it is a registered copy of the last completed load.
- mem_wdata = d_wdata at all times.
- conflict_cnt increments on every cycle with stall_if=1 and saturates at 2^CNT_W-1.

## Timing
- Reset (rst=0 at a clock edge) sets state to S_FETCH, wcnt=0, d_rdata register=0 and conflict_cnt=0.
- While rst=0, all outputs are forced to 0, including mem_wr, so a partial store is never committed.
- A reset in the middle of an access abandons the access, with no d_done and no if_valid.
- WAIT_STATES=0 gives single-cycle access:
  - A fetch with no conflict has if_valid in the same cycle.
  - A data access completes in its request cycle, costing exactly one fetch bubble (stall_if=1 for 1 cycle, stall_mem=0).
- WAIT_STATES=N:
  - Fetch latency is N+1 cycles.
  - A data access holds stall_mem for N cycles, with d_done in cycle N+1.
  - stall_if is held for N+1 cycles, plus the remaining cycles of any in-progress fetch.
- Back-to-back data requests (next request present in the cycle after d_done) may grant data again. Fetch gets the port only in a cycle with no data request.
- wcnt wraps to 0 after every completed access.

## Structure
- Package mem_arb_pkg holds:
  - state encoding constants S_FETCH and S_DATA
  - the NOP encoding 32'h00000013
  - WAIT_STATES legality bounds
- Sub-module sat_counter (parameter W, inputs inc and clr, output q) implements conflict_cnt and is reusable for other performance counters.
- The FSM, wait counter and port mux stay in the top level.

## Test plan
- **Fetch-only, WAIT_STATES=0.** Drive if_req=1 with if_addr=0,1,2,... → expect if_valid=1 every cycle, if_data=mem[addr], stall_if=0, conflict_cnt stays 0.
- **Single load, WAIT_STATES=0.** Load with d_addr=5 and mem[5]=32'hDEADBEEF → in the same cycle expect d_done=1, d_rdata=32'hDEADBEEF, stall_if=1, stall_mem=0. Then conflict_cnt=1.
- **Store, WAIT_STATES=2.** Store d_wdata=32'h12345678 to d_addr=3 → expect stall_mem=1 for 2 cycles, mem_wr=1 only in cycle 3 together with d_done=1. A later fetch of address 3 returns 32'h12345678.
- **Load arriving mid-fetch, WAIT_STATES=1.** Load arrives in the cycle after a fetch starts → the fetch completes first (if_valid=1), and stall_mem stays 1. The load then runs for 2 cycles, and stall_mem stays 1 until d_done=1.
- **Reset during a store, WAIT_STATES=3.** Assert rst=0 in the second cycle of the store → mem_wr never goes to 1 and the memory contents are unchanged. After release, the state is S_FETCH and conflict_cnt=0.
- **Counter saturation, CNT_W=2.** Issue 5 back-to-back loads → conflict_cnt reads 3 and stays at 3.
